// File: rtl/joybus_pkg.sv
// Shared types and constants for the joybus CRC-8 receive path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: CRC width/polynomial, the receive FSM state encoding and the
// single-bit CRC step shared by the LFSR and the frame-end capture logic.
package joybus_pkg;

  localparam int              CRC_WIDTH = 8;
  // x^8 + x^7 + x^2 + 1; the x^8 term is implicit in the shift-out.
  localparam logic [7:0]      CRC_POLY  = 8'h85;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2,
    DONE = 2'd3
  } state_t;

  // One augmented-CRC step: shift the new bit in at the bottom and fold the
  // bit that falls off the top back in through the polynomial taps.
  function automatic logic [CRC_WIDTH-1:0] crc8_step(
    input logic [CRC_WIDTH-1:0] crc,
    input logic                 d,
    input logic [CRC_WIDTH-1:0] poly
  );
    logic [CRC_WIDTH-1:0] shifted;
    shifted = {crc[CRC_WIDTH-2:0], d};
    return crc[CRC_WIDTH-1] ? (shifted ^ poly) : shifted;
  endfunction

endpackage

// File: rtl/crc8_lfsr.sv
// Bit-serial CRC-8 register, one step per cycle while step is high.
// Latency: crc reflects a step on the cycle after the step edge.
// Backpressure: none; the caller simply holds step low to pause.
//
// Ports:
//   clk, reset  clock and synchronous active-high reset (register -> 0)
//   clear       load seed (wins over step)
//   seed[7:0]   value loaded on clear
//   step, d     advance one bit with input bit d
//   crc[7:0]    current register value
module crc8_lfsr
  import joybus_pkg::*;
#(
  parameter logic [CRC_WIDTH-1:0] POLY = CRC_POLY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [CRC_WIDTH-1:0] seed,
  input  logic                 step,
  input  logic                 d,
  output logic [CRC_WIDTH-1:0] crc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      crc <= '0;
    end else if (clear) begin
      crc <= seed;
    end else if (step) begin
      crc <= crc8_step(crc, d, POLY);
    end
  end

endmodule

// File: rtl/joybus_crc_checker.sv
// Deserialises a joybus pak data block plus trailing CRC byte and checks the CRC.
// Latency: byte_valid 1 cycle after the 8th bit of a byte; frame_done 2 cycles after the last CRC bit.
// Backpressure: none; the receiver cannot be stalled, gaps in bit_valid are simply waited out.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset (back to IDLE, outputs cleared)
//   start          pulse: (re)arm for a new frame from any state
//   bit_valid      bit_in carries a received bit this cycle
//   bit_in         received serial bit, MSB of each byte first
//   byte_out[7:0]  last completed data byte, byte_idx[4:0] its position in the frame
//   byte_valid     pulse qualifying byte_out/byte_idx
//   busy           frame in progress (DATA or CRC)
//   frame_done     pulse, crc_ok/rx_crc/calc_crc are valid
//   crc_ok         calc_crc == rx_crc, held until the next start
//   rx_crc[7:0]    CRC byte taken from the wire
//   calc_crc[7:0]  locally computed CRC
module joybus_crc_checker
  import joybus_pkg::*;
#(
  parameter int                   DATA_BYTES = 32,
  parameter logic [CRC_WIDTH-1:0] SEED       = 8'h00,
  parameter logic [CRC_WIDTH-1:0] POLY       = CRC_POLY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  output logic [7:0]           byte_out,
  output logic                 byte_valid,
  output logic [4:0]           byte_idx,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 crc_ok,
  output logic [CRC_WIDTH-1:0] rx_crc,
  output logic [CRC_WIDTH-1:0] calc_crc
);

  localparam logic [4:0] LAST_IDX = 5'(DATA_BYTES - 1);

  state_t               state_q;
  state_t               state_d;

  logic [2:0]           bit_cnt_q;   // bit position within the current byte
  logic [4:0]           byte_cnt_q;  // data byte index within the frame
  logic [6:0]           sr_q;        // first 7 bits of the byte being assembled

  logic                 in_data;
  logic                 in_crc;
  logic                 accept;      // a bit that actually advances the frame
  logic                 byte_end;    // accepted bit completes a byte
  logic                 lfsr_d;
  logic [CRC_WIDTH-1:0] lfsr_crc;

  // ------------------------------------------------------------------
  // Next-state and qualifier logic
  // ------------------------------------------------------------------
  always_comb begin
    in_data  = 1'b0;
    in_crc   = 1'b0;
    accept   = 1'b0;
    byte_end = 1'b0;
    lfsr_d   = 1'b0;
    busy     = 1'b0;
    state_d  = state_q;

    in_data = (state_q == DATA);
    in_crc  = (state_q == CRC);
    busy    = in_data || in_crc;

    // start restarts the frame, so a bit presented alongside it belongs to
    // nothing and is dropped.
    accept   = bit_valid && !start && busy;
    byte_end = accept && (bit_cnt_q == 3'd7);

    // While the CRC byte arrives the register is fed zeros: these are the
    // eight augment bits, flushed in parallel with reception.
    lfsr_d = in_data ? bit_in : 1'b0;

    if (start) begin
      state_d = DATA;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        DATA: if (byte_end && (byte_cnt_q == LAST_IDX)) state_d = CRC;
        CRC:  if (byte_end) state_d = DONE;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------
  // CRC register
  // ------------------------------------------------------------------
  crc8_lfsr #(
    .POLY (POLY)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .seed  (SEED),
    .step  (accept),
    .d     (lfsr_d),
    .crc   (lfsr_crc)
  );

  // ------------------------------------------------------------------
  // Counters, byte assembly and frame-end capture
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      sr_q       <= '0;
      byte_out   <= '0;
      byte_idx   <= '0;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      rx_crc     <= '0;
      calc_crc   <= '0;
    end else begin
      byte_valid <= 1'b0;
      frame_done <= 1'b0;

      if (start) begin
        bit_cnt_q  <= '0;
        byte_cnt_q <= '0;
        sr_q       <= '0;
        crc_ok     <= 1'b0;
      end else begin
        if (accept) begin
          // The same shifter collects data bytes and the CRC byte; the
          // counter wraps back to 0 naturally at each byte boundary.
          bit_cnt_q <= bit_cnt_q + 3'd1;
          sr_q      <= {sr_q[5:0], bit_in};
        end

        if (byte_end && in_data) begin
          byte_out   <= {sr_q, bit_in};
          byte_idx   <= byte_cnt_q;
          byte_valid <= 1'b1;
          byte_cnt_q <= byte_cnt_q + 5'd1;
        end

        // The register only reaches its final value at this same edge, so
        // capture the post-step value directly rather than wait a cycle.
        if (byte_end && in_crc) begin
          rx_crc   <= {sr_q, bit_in};
          calc_crc <= crc8_step(lfsr_crc, 1'b0, POLY);
        end

        if (state_q == DONE) begin
          frame_done <= 1'b1;
          crc_ok     <= (calc_crc == rx_crc);
        end
      end
    end
  end

endmodule
